clk_ctrl_gen: RTL and testbench

//  Parametrised clock-control block for the CPU test platform: free-running divider count, N programmable

---
 rtl/clk_ctrl_gen.sv | 165 ++++++++++++++++
 tb/tb_clk_ctrl_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_ctrl_gen.sv
// Clock-control block: free-running divider, N programmable tick channels and a CPU
// clock-enable with HALT/RUN/SLOW/STEP modes; everything is an enable on clk, never a clock.
module clk_ctrl_gen #(
    parameter int unsigned      CNT_W   = 32,
    parameter int unsigned      N_CH    = 4,
    parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(24'hFFFFFF),
    parameter int unsigned      DEB_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [3:0]       slow_sel,
    input  logic             div_we,
    input  logic [3:0]       div_idx,
    input  logic [CNT_W-1:0] div_val,
    input  logic             step_btn,
    input  logic             ce_clr,
    output logic [CNT_W-1:0] clkdiv,
    output logic [N_CH-1:0]  ch_tick,
    output logic             cpu_ce,
    output logic [1:0]       mode_q,
    output logic [CNT_W-1:0] ce_cnt
);

    typedef enum logic [1:0] {
        MODE_HALT = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_STEP = 2'd3
    } mode_e;

    localparam int unsigned      DEB_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

    logic [CNT_W-1:0] clkdiv_q, clkdiv_d;
    mode_e            mode_cur_q, mode_cur_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic [CNT_W-1:0] ce_cnt_q, ce_cnt_d;

    logic             sync1_q, sync2_q;
    logic             deb_q, deb_d, deb_prev_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             step_req;
    logic [15:0]      tick_ext;

    // ------------------------------------------------------------------
    // Programmable tick channels
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] div_q, div_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             tick_q, tick_d;
        logic             wr_hit;

        // Out-of-range indices match no channel, so such writes fall away here.
        assign wr_hit = div_we && (div_idx == 4'(i));

        // NOTE: every variable gets a default before any branch, otherwise the
        // paths that skip an assignment would infer a latch.
        always_comb begin
            div_d  = div_q;
            cnt_d  = cnt_q + CNT_W'(1);
            tick_d = 1'b0;
            if (wr_hit) begin
                div_d = div_val;
                cnt_d = '0;
            end else if (cnt_q == div_q) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end
        end

        // NOTE: the divisors are plain per-channel flops, not a RAM, so they can
        // and must take DIV_RST on reset like any other state.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                div_q  <= DIV_RST;
                cnt_q  <= '0;
                tick_q <= 1'b0;
            end else begin
                div_q  <= div_d;
                cnt_q  <= cnt_d;
                tick_q <= tick_d;
            end
        end

        assign ch_tick[i] = tick_q;
    end

    // Zero-extend so any 4-bit slow_sel indexes safely; missing channels read as 0.
    assign tick_ext = 16'(ch_tick);

    // ------------------------------------------------------------------
    // Step button: 2-flop synchroniser and debouncer
    // ------------------------------------------------------------------
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    assign step_req = deb_q & ~deb_prev_q;

    // ------------------------------------------------------------------
    // Mode register, CPU clock enable and enable counter
    // ------------------------------------------------------------------
    always_comb begin
        clkdiv_d   = clkdiv_q + CNT_W'(1);
        mode_cur_d = mode_e'(mode);
        cpu_ce_d   = 1'b0;
        case (mode_cur_q)
            MODE_HALT: cpu_ce_d = 1'b0;
            MODE_RUN:  cpu_ce_d = 1'b1;
            MODE_SLOW: cpu_ce_d = tick_ext[slow_sel];
            MODE_STEP: cpu_ce_d = step_req;
            default:   cpu_ce_d = 1'b0;
        endcase

        // Clear wins over a simultaneous enable pulse.
        ce_cnt_d = ce_cnt_q;
        if (ce_clr) begin
            ce_cnt_d = '0;
        end else if (cpu_ce_q) begin
            ce_cnt_d = ce_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkdiv_q   <= '0;
            mode_cur_q <= MODE_HALT;
            cpu_ce_q   <= 1'b0;
            ce_cnt_q   <= '0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            deb_cnt_q  <= '0;
        end else begin
            clkdiv_q   <= clkdiv_d;
            mode_cur_q <= mode_cur_d;
            cpu_ce_q   <= cpu_ce_d;
            ce_cnt_q   <= ce_cnt_d;
            sync1_q    <= step_btn;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            deb_cnt_q  <= deb_cnt_d;
        end
    end

    assign clkdiv = clkdiv_q;
    assign mode_q = mode_cur_q;
    assign cpu_ce = cpu_ce_q;
    assign ce_cnt = ce_cnt_q;

endmodule

// File: tb/tb_clk_ctrl_gen.sv
// Bench for clk_ctrl_gen: directed stimulus; expected cpu_ce pulse times go into a
// scoreboard queue that a separate negedge monitor pops and compares.
module tb_clk_ctrl_gen;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned N_CH    = 4;
    localparam int unsigned DEB_CYC = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       mode;
    logic [3:0]       slow_sel;
    logic             div_we;
    logic [3:0]       div_idx;
    logic [CNT_W-1:0] div_val;
    logic             step_btn;
    logic             ce_clr;
    logic [CNT_W-1:0] clkdiv;
    logic [N_CH-1:0]  ch_tick;
    logic             cpu_ce;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] ce_cnt;

    clk_ctrl_gen #(
        .CNT_W  (CNT_W),
        .N_CH   (N_CH),
        .DIV_RST(32'd7),
        .DEB_CYC(DEB_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .slow_sel(slow_sel),
        .div_we  (div_we),
        .div_idx (div_idx),
        .div_val (div_val),
        .step_btn(step_btn),
        .ce_clr  (ce_clr),
        .clkdiv  (clkdiv),
        .ch_tick (ch_tick),
        .cpu_ce  (cpu_ce),
        .mode_q  (mode_q),
        .ce_cnt  (ce_cnt)
    );

    always #5 clk = ~clk;

    // Reference edge count since the last reset release.
    int unsigned ecount = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    int nerr = 0;
    int nchk = 0;
    int unsigned exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%0h expected=%0h (edge %0d)", name, act, exp, ecount);
        end
    endtask

    // Scoreboard monitor: each cpu_ce pulse must match the oldest expected edge.
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0] < ecount) begin
                check("ce_pulse_missed", 64'(ecount), 64'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            if (cpu_ce) begin
                if (exp_q.size() == 0) begin
                    check("ce_unexpected", 64'(cpu_ce), 64'd0);
                end else begin
                    check("ce_pulse_time", 64'(ecount), 64'(exp_q[0]));
                    if (exp_q[0] == ecount) void'(exp_q.pop_front());
                end
            end
        end
    end

    int unsigned e0, w1, w3, h;
    logic [3:0]  ev;

    initial begin
        mode = 2'd0; slow_sel = 4'd0; div_we = 1'b0; div_idx = 4'd0;
        div_val = '0; step_btn = 1'b0; ce_clr = 1'b0;

        // Reset state
        #2;
        check("rst_clkdiv", clkdiv, 0);
        check("rst_ch_tick", ch_tick, 0);
        check("rst_cpu_ce", cpu_ce, 0);
        check("rst_mode_q", mode_q, 0);
        check("rst_ce_cnt", ce_cnt, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // Reset divisor 7: every channel ticks every 8 cycles; clkdiv counts edges
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            check("clkdiv_count", clkdiv, n);
            check("rst_div_tick", ch_tick, (n % 8 == 0) ? 4'hF : 4'h0);
        end

        // T1: RUN until ce_cnt=37, then asynchronous reset between edges
        mode = 2'd1;
        e0 = ecount;
        for (int j = 2; j <= 39; j++) exp_q.push_back(e0 + j);
        repeat (39) @(negedge clk);
        check("t1_ce_cnt_37", ce_cnt, 37);
        check("t1_cpu_ce_run", cpu_ce, 1);
        #2 rst = 1'b1; mode = 2'd0;
        #1;
        check("t1_async_clkdiv", clkdiv, 0);
        check("t1_async_ch_tick", ch_tick, 0);
        check("t1_async_cpu_ce", cpu_ce, 0);
        check("t1_async_mode_q", mode_q, 0);
        check("t1_async_ce_cnt", ce_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            check("t1_clkdiv_after", clkdiv, n);
        end

        // T2: channel 1 divisor 3 -> tick every 4 cycles after the write edge
        div_we = 1'b1; div_idx = 4'd1; div_val = 32'd3;
        @(negedge clk);
        div_we = 1'b0;
        w1 = ecount;
        check("t2_write_edge_tick", ch_tick[1], 0);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            check("t2_div3_tick", ch_tick[1], (n % 4 == 0));
        end
        // divisor 0 -> high every cycle from the edge after the write
        div_we = 1'b1; div_val = 32'd0;
        @(negedge clk);
        div_we = 1'b0;
        check("t2_div0_write_edge", ch_tick[1], 0);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            check("t2_div0_tick", ch_tick[1], 1);
        end

        // T3: divisor 3 again, SLOW on channel 1 -> one-cycle cpu_ce every 4 cycles
        div_we = 1'b1; div_val = 32'd3;
        @(negedge clk);
        div_we = 1'b0;
        w3 = ecount;
        mode = 2'd2; slow_sel = 4'd1;
        exp_q.push_back(w3 + 5);
        exp_q.push_back(w3 + 9);
        exp_q.push_back(w3 + 13);
        repeat (14) @(negedge clk);
        check("t3_mode_q_slow", mode_q, 2);
        slow_sel = 4'd9;
        repeat (12) @(negedge clk);
        mode = 2'd0;
        @(negedge clk);
        check("t3_ce_cnt", ce_cnt, 3);

        // T4: STEP with 2-cycle bounces, then a 10-cycle hold -> one pulse
        ce_clr = 1'b1;
        @(negedge clk);
        ce_clr = 1'b0;
        check("t4_ce_clr", ce_cnt, 0);
        mode = 2'd3;
        repeat (2) @(negedge clk);
        repeat (2) begin
            step_btn = 1'b1; repeat (2) @(negedge clk);
            step_btn = 1'b0; repeat (2) @(negedge clk);
        end
        h = ecount;
        step_btn = 1'b1;
        exp_q.push_back(h + 7);
        repeat (10) @(negedge clk);
        step_btn = 1'b0;
        repeat (12) @(negedge clk);
        check("t4_ce_cnt_step", ce_cnt, 1);

        // T5: press during RUN, then STEP -> the press is not replayed
        e0 = ecount;
        mode = 2'd1; step_btn = 1'b1;
        for (int j = 2; j <= 13; j++) exp_q.push_back(e0 + j);
        repeat (12) @(negedge clk);
        mode = 2'd3;
        repeat (12) @(negedge clk);
        check("t5_ce_cnt", ce_cnt, 13);
        step_btn = 1'b0;
        repeat (10) @(negedge clk);
        mode = 2'd0;

        // T6: write to div_idx=N_CH changes nothing; phases continue
        div_we = 1'b1; div_idx = 4'(N_CH); div_val = 32'd0;
        @(negedge clk);
        div_we = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            ev = (ecount % 8 == 0) ? 4'hF : 4'h0;
            ev[1] = ((ecount - w3) % 4 == 0);
            check("t6_bad_idx_ticks", ch_tick, ev);
        end
        // ce_clr while cpu_ce=1, combined with RUN->HALT
        e0 = ecount;
        mode = 2'd1;
        for (int j = 2; j <= 4; j++) exp_q.push_back(e0 + j);
        repeat (3) @(negedge clk);
        check("t6_ce_cnt_pre", ce_cnt, 14);
        ce_clr = 1'b1; mode = 2'd0;
        @(negedge clk);
        ce_clr = 1'b0;
        check("t6_clr_priority", ce_cnt, 0);
        check("t6_ce_high_after_switch", cpu_ce, 1);
        @(negedge clk);
        check("t6_ce_low_after_halt", cpu_ce, 0);
        check("t6_ce_cnt_post", ce_cnt, 1);
        repeat (3) @(negedge clk);
        check("t6_ce_cnt_hold", ce_cnt, 1);

        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
